mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory controller; sits directly upstream of the MEM/WB pipeline register.
//  - Drives loads and stores onto a req/ack data-SRAM port.
//  - Byte-lane aligns store data and sign/zero-extends load data.
//  - Produces ReadDataM for the MEM/WB register.
//  - Raises StallM while an access is outstanding.
// PARAMETERS
//  DATA_W   32  data bus width; only 32 is supported
//  ADDR_W   32  byte address width
// PORTS
//  clock            in   1       rising-edge clock
//  reset            in   1       asynchronous, active-low reset (0 = reset)
//  MemReadM         in   1       load in MEM stage
//  MemWriteM        in   1       store in MEM stage
//  MemOpM           in   3       `MEM_LB/LBU/LH/LHU/LW/SB/SH/SW
//  ALUOutM          in   ADDR_W  effective byte address
//  WriteDataM       in   DATA_W  raw store data (rt)
//  FlushM           in   1       kill the MEM-stage instruction
//  StallOtherM      in   1       pipeline held by another source
//  data_req         out  1       access request; held until data_ack
//  data_wen         out  4       byte write enables; 0000 = read
//  data_addr        out  ADDR_W  word-aligned address {ALUOutM[31:2],2'b00}
//  data_wdata       out  DATA_W  lane-replicated store data
//  data_ack         in   1       access complete; data_rdata valid in the same cycle
//  data_rdata       in   DATA_W  raw read word
//  ReadDataM        out  DATA_W  formatted load result
//  StallM           out  1       freeze IF..MEM
//  AdelM / AdesM    out  1       load / store address error
//  BadVAddrM        out  ADDR_W  faulting address
// BEHAVIOUR
//  States: IDLE, BUSY, DONE, DRAIN. Reset sets state=IDLE and the registered read data to 0.
//  Start condition: go = (MemReadM|MemWriteM) & ~FlushM & ~addr_err.
//  data_req (combinational):
//   - 1 in IDLE when go; 1 in BUSY and DRAIN; 0 in DONE.
//   - While data_req is high, data_addr, data_wen and data_wdata stay stable until data_ack.
//  Latency:
//   - Zero-wait: data_ack in the issuing cycle. Nothing stalls; ReadDataM is taken combinationally from data_rdata.
//   - Otherwise StallM = data_req & ~data_ack.
//  Transitions:
//   - IDLE --go & ~data_ack--> BUSY
//   - IDLE/BUSY --data_ack & StallOtherM--> DONE; the formatted read data is registered.
//   - BUSY --data_ack & ~StallOtherM--> IDLE
//   - DONE --~StallOtherM--> IDLE. DONE never re-issues; ReadDataM comes from the registered value.
//   - BUSY --FlushM--> DRAIN
//   - DRAIN --data_ack--> IDLE; read data is discarded.
//  Stalls during DRAIN: the request cannot be withdrawn, so StallM=1 in DRAIN until data_ack.
//  Store lanes, with o = ALUOutM[1:0]:
//   - SB: wen = 4'b0001<<o; wdata = {4{WriteDataM[7:0]}}
//   - SH: wen = o[1] ? 1100 : 0011; wdata = {2{WriteDataM[15:0]}}
//   - SW: wen = 1111
//   - Loads: wen = 0000
//  Load formatting:
//   - LB/LBU select byte o; LH/LHU select half o[1].
//   - Signed ops sign-extend; U variants zero-extend; LW passes through.
//  ReadDataM is 0 when no load completes in the cycle and the state is not DONE.
//  Reset mid-access: state returns to IDLE and data_req drops immediately. The SRAM side must also be in reset.
//  Simultaneous FlushM and data_ack in BUSY: the ack wins, the data is discarded, and the next state is IDLE.
// CONFIGURATION
//  MEM_ADDR_EXC_EN defined:
//   - addr_err = (LH/LHU/SH & o[0]) | (LW/SW & |o).
//   - No request is issued; AdelM (load) or AdesM (store) is driven high combinationally.
//   - BadVAddrM = ALUOutM.
//  MEM_ADDR_EXC_EN undefined:
//   - addr_err=0; AdelM=AdesM=0; BadVAddrM=0.
//   - The access is issued with the misaligned low bits ignored.
// STRUCTURE
//  defines.vh holds the `MEM_* MemOpM encodings and the FSM state localparams (2 bits).
//  Sub-module mem_data_align (combinational) covers store lane/wen generation and load extension.
//  The FSM, the read-data hold register and the stall logic stay in this module.
// TESTING
//  1. LB, addr 0x...3, zero-wait ack, rdata=0x80FF_FF00 -> ReadDataM=0xFFFF_FF80, StallM never 1.
//  2. SH, addr 0x...2, WriteDataM=0x1234_ABCD, ack after 3 cycles:
//     data_wen=1100, data_wdata=0xABCD_ABCD, StallM=1 for exactly 3 cycles, req stable throughout.
//  3. LW acked while StallOtherM=1 for 2 more cycles:
//     ReadDataM holds the captured word, data_req=0, no duplicate access.
//  4. FlushM in BUSY of an LHU: StallM stays 1 until ack, the data is discarded, then IDLE with no new request.
//  5. MEM_ADDR_EXC_EN, LW addr 0x1001: data_req=0, AdelM=1, BadVAddrM=0x1001.
//     Without the macro: the access is issued at 0x1000.
//  6. reset=0 asserted during BUSY: data_req and StallM drop asynchronously; state=IDLE.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: MemOpM encodings, FSM state codes and alignment helper
// shared by the MEM-stage data-memory controller.
package mem_access_ctrl_pkg;
    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LBU = 3'd1;
    localparam logic [2:0] MEM_LH  = 3'd2;
    localparam logic [2:0] MEM_LHU = 3'd3;
    localparam logic [2:0] MEM_LW  = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && off[0]) ||
               ((op == MEM_LW || op == MEM_SW) && off != 2'b00);
    endfunction
endpackage

// File: rtl/mem_data_align.sv
// mem_data_align: store byte-lane enables/replication and load byte/half
// selection with sign or zero extension (purely combinational).
module mem_data_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata_raw,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_raw >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        wen = op == MEM_SB ? 4'b0001 << off :
              op == MEM_SH ? (off[1] ? 4'b1100 : 4'b0011) :
              op == MEM_SW ? 4'b1111 : 4'b0000;
        wdata = op == MEM_SB ? {4{wdata_raw[7:0]}} :
                op == MEM_SH ? {2{wdata_raw[15:0]}} : wdata_raw;
        rdata = op == MEM_LB  ? {{24{b[7]}}, b} :
                op == MEM_LBU ? {24'h0, b} :
                op == MEM_LH  ? {{16{h[15]}}, h} :
                op == MEM_LHU ? {16'h0, h} : rdata_raw;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage req/ack data-SRAM controller with stall and read-data hold.
// Optional MEM_ADDR_EXC_EN: misaligned accesses raise AdelM/AdesM instead of issuing.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        MemOpM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              FlushM,
    input  logic              StallOtherM,
    output logic              data_req,
    output logic [3:0]        data_wen,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_ack,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              AdelM,
    output logic              AdesM,
    output logic [ADDR_W-1:0] BadVAddrM
);
    logic [1:0]        state, nxt;
    logic [2:0]        op_q, cur_op;
    logic [ADDR_W-1:0] addr_q, cur_addr;
    logic [DATA_W-1:0] wd_q, cur_wd, rdata_q, fmt, lane_wd, rd_now;
    logic              rd_q, wr_q, cur_rd, cur_wr;
    logic              idle, go, addr_err, done_ok;
    logic [3:0]        lane_wen;

    assign idle = state == S_IDLE;

`ifdef MEM_ADDR_EXC_EN
    assign addr_err  = (MemReadM | MemWriteM) & misaligned(MemOpM, ALUOutM[1:0]);
    assign AdelM     = MemReadM & addr_err;
    assign AdesM     = MemWriteM & addr_err;
    assign BadVAddrM = ALUOutM;
`else
    assign addr_err  = 1'b0;
    assign AdelM     = 1'b0;
    assign AdesM     = 1'b0;
    assign BadVAddrM = '0;
`endif

    // Reset gates go so the request drops as soon as reset asserts.
    assign go = reset & (MemReadM | MemWriteM) & ~FlushM & ~addr_err;

    // Outstanding accesses drive the SRAM from the captured copy, keeping it stable.
    assign cur_op   = idle ? MemOpM     : op_q;
    assign cur_addr = idle ? ALUOutM    : addr_q;
    assign cur_wd   = idle ? WriteDataM : wd_q;
    assign cur_rd   = idle ? MemReadM   : rd_q;
    assign cur_wr   = idle ? MemWriteM  : wr_q;

    mem_data_align u_align (
        .op       (cur_op),
        .off      (cur_addr[1:0]),
        .wdata_raw(cur_wd),
        .rdata_raw(data_rdata),
        .wen      (lane_wen),
        .wdata    (lane_wd),
        .rdata    (fmt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = !go ? S_IDLE : !data_ack ? S_BUSY : StallOtherM ? S_DONE : S_IDLE;
            S_BUSY:  nxt = data_ack ? ((StallOtherM & ~FlushM) ? S_DONE : S_IDLE) :
                           FlushM ? S_DRAIN : S_BUSY;
            S_DONE:  nxt = StallOtherM ? S_DONE : S_IDLE;
            default: nxt = data_ack ? S_IDLE : S_DRAIN;
        endcase
    end

    always_comb begin
        data_req   = (idle & go) | state == S_BUSY | state == S_DRAIN;
        data_wen   = cur_wr ? lane_wen : 4'b0000;
        data_addr  = {cur_addr[ADDR_W-1:2], 2'b00};
        data_wdata = lane_wd;
        done_ok    = data_ack & data_req & state != S_DRAIN & ~(state == S_BUSY & FlushM);
        rd_now     = (done_ok & cur_rd) ? fmt : '0;
        ReadDataM  = state == S_DONE ? rdata_q : rd_now;
        StallM     = data_req & ~data_ack;
    end

    // rdata_q tracks the completion value until DONE freezes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q    <= MEM_LB;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (idle) begin
                op_q   <= MemOpM;
                addr_q <= ALUOutM;
                wd_q   <= WriteDataM;
                rd_q   <= MemReadM;
                wr_q   <= MemWriteM;
            end
            if (state != S_DONE) rdata_q <= rd_now;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clock = 1'b0, reset = 1'b0;
    logic        MemReadM, MemWriteM, FlushM, StallOtherM, data_ack;
    logic [2:0]  MemOpM;
    logic [31:0] ALUOutM, WriteDataM, data_rdata;
    logic        data_req, StallM, AdelM, AdesM;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, ReadDataM, BadVAddrM;

    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    mem_access_ctrl dut (
        .clock(clock), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemOpM(MemOpM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .FlushM(FlushM),
        .StallOtherM(StallOtherM), .data_req(data_req), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
        .data_rdata(data_rdata), .ReadDataM(ReadDataM), .StallM(StallM),
        .AdelM(AdelM), .AdesM(AdesM), .BadVAddrM(BadVAddrM)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] s, hw;
        s  = w >> (8 * int'(off));
        hw = w >> (off >= 2'd2 ? 16 : 0);
        case (op)
            MEM_LB:  return {{24{s[7]}}, s[7:0]};
            MEM_LBU: return {24'h0, s[7:0]};
            MEM_LH:  return {{16{hw[15]}}, hw[15:0]};
            MEM_LHU: return {16'h0, hw[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_wen(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEM_SB:  return 4'(1 << int'(off));
            MEM_SH:  return off >= 2'd2 ? 4'hC : 4'h3;
            MEM_SW:  return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] op, input logic [31:0] w);
        case (op)
            MEM_SB:  return {24'h0, w[7:0]} * 32'h0101_0101;
            MEM_SH:  return {16'h0, w[15:0]} * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] op, input logic [1:0] off);
`ifdef MEM_ADDR_EXC_EN
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return int'(off) % 2 != 0;
        if (op == MEM_LW || op == MEM_SW) return off != 2'd0;
`endif
        return 1'b0;
    endfunction

    task automatic idle_in;
        MemReadM = 0; MemWriteM = 0; FlushM = 0; StallOtherM = 0; data_ack = 0;
        MemOpM = MEM_LW; ALUOutM = 0; WriteDataM = 0; data_rdata = 0;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Model: an optional outstanding access (pend, maybe killed) or a held result.
    bit          pend, kill, hold, e_start, e_req, e_stall, aerr, hold_pipe;
    logic [31:0] p_addr, p_wd, hval, e_rd, w_addr, w_wd;
    logic [3:0]  p_wen, w_wen;
    logic [2:0]  p_op;
    logic [1:0]  p_off;
    bit          p_ld;
    int          k;

    initial begin
        idle_in;
        chk("model_lb", ref_load(MEM_LB, 2'd3, 32'h80FF_FF00), 32'hFFFF_FF80);
        chk("model_lhu", ref_load(MEM_LHU, 2'd2, 32'h8765_4321), 32'h0000_8765);
        chk("model_sb", ref_wd(MEM_SB, 32'h0000_00A5), 32'hA5A5_A5A5);
        #12;
        chk("rst_req", data_req, 0);
        chk("rst_rd", ReadDataM, 0);
        chk("rst_stall", StallM, 0);
        @(posedge clock);
        #1 reset = 1;

        // LB zero-wait
        MemReadM = 1; MemOpM = MEM_LB; ALUOutM = 32'h1003; data_ack = 1; data_rdata = 32'h80FF_FF00;
        #1;
        chk("lb_req", data_req, 1);
        chk("lb_addr", data_addr, 32'h1000);
        chk("lb_wen", data_wen, 0);
        chk("lb_stall", StallM, 0);
        chk("lb_rd", ReadDataM, 32'hFFFF_FF80);
        step; idle_in; #1;
        chk("lb_after_req", data_req, 0);
        chk("lb_after_rd", ReadDataM, 0);

        // SH with three wait cycles
        step;
        MemWriteM = 1; MemOpM = MEM_SH; ALUOutM = 32'h2002; WriteDataM = 32'h1234_ABCD;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("sh_req", data_req, 1);
            chk("sh_wen", data_wen, 4'b1100);
            chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
            chk("sh_addr", data_addr, 32'h2000);
            chk("sh_stall", StallM, 1);
            step;
        end
        data_ack = 1; #1;
        chk("sh_ack_req", data_req, 1);
        chk("sh_ack_wen", data_wen, 4'b1100);
        chk("sh_ack_stall", StallM, 0);
        step; idle_in; #1;
        chk("sh_idle_req", data_req, 0);

        // LW acked while another stall holds the pipeline
        step;
        MemReadM = 1; MemOpM = MEM_LW; ALUOutM = 32'h3000; data_ack = 1;
        data_rdata = 32'hDEAD_BEEF; StallOtherM = 1; #1;
        chk("lw_rd", ReadDataM, 32'hDEAD_BEEF);
        chk("lw_stall", StallM, 0);
        step; data_ack = 0; data_rdata = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("lw_hold_req", data_req, 0);
            chk("lw_hold_rd", ReadDataM, 32'hDEAD_BEEF);
            step;
        end
        StallOtherM = 0; #1;
        chk("lw_rel_req", data_req, 0);
        chk("lw_rel_rd", ReadDataM, 32'hDEAD_BEEF);
        step; idle_in; #1;
        chk("lw_end_req", data_req, 0);
        chk("lw_end_rd", ReadDataM, 0);

        // LHU flushed while waiting
        step;
        MemReadM = 1; MemOpM = MEM_LHU; ALUOutM = 32'h4002; #1;
        chk("lhu_stall", StallM, 1);
        step; FlushM = 1; #1;
        chk("lhu_flush_req", data_req, 1);
        chk("lhu_flush_stall", StallM, 1);
        step; FlushM = 0; #1;
        chk("drain_req", data_req, 1);
        chk("drain_stall", StallM, 1);
        chk("drain_addr", data_addr, 32'h4000);
        step; data_ack = 1; data_rdata = 32'h1234_5678; #1;
        chk("drain_ack_stall", StallM, 0);
        chk("drain_ack_rd", ReadDataM, 0);
        step; idle_in; #1;
        chk("drain_end_req", data_req, 0);

        // misaligned LW
        step;
        MemReadM = 1; MemOpM = MEM_LW; ALUOutM = 32'h1001; data_ack = 1; data_rdata = 32'hCAFE_F00D; #1;
`ifdef MEM_ADDR_EXC_EN
        chk("mis_req", data_req, 0);
        chk("mis_adel", AdelM, 1);
        chk("mis_badv", BadVAddrM, 32'h1001);
`else
        chk("mis_req", data_req, 1);
        chk("mis_addr", data_addr, 32'h1000);
        chk("mis_adel", AdelM, 0);
        chk("mis_badv", BadVAddrM, 0);
        chk("mis_rd", ReadDataM, 32'hCAFE_F00D);
`endif
        step; idle_in;

        // reset during an outstanding SW
        step;
        MemWriteM = 1; MemOpM = MEM_SW; ALUOutM = 32'h5000; WriteDataM = 32'h1122_3344; #1;
        chk("sw_wen", data_wen, 4'hF);
        step; #1;
        chk("sw_busy_req", data_req, 1);
        chk("sw_busy_stall", StallM, 1);
        reset = 0; #1;
        chk("sw_rst_req", data_req, 0);
        chk("sw_rst_stall", StallM, 0);
        MemWriteM = 0;
        step; reset = 1; #1;
        chk("post_rst_req", data_req, 0);
        chk("post_rst_rd", ReadDataM, 0);

        // randomized traffic
        pend = 0; kill = 0; hold = 0; e_stall = 0; hval = 0;
        for (int i = 0; i < 3000; i++) begin
            hold_pipe = e_stall | StallOtherM;
            if (!hold_pipe) begin
                k = $urandom_range(0, 3);
                MemReadM = k == 1 || k == 3;
                MemWriteM = k == 2;
                MemOpM = MemReadM ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
                ALUOutM = $urandom;
                WriteDataM = $urandom;
            end
            FlushM = $urandom_range(0, 9) == 0;
            StallOtherM = $urandom_range(0, 9) < 3;
            data_ack = $urandom_range(0, 9) < 4;
            data_rdata = $urandom;
            @(negedge clock);
            aerr = (MemReadM | MemWriteM) && ref_err(MemOpM, ALUOutM[1:0]);
            e_start = 0;
            w_addr = 0; w_wen = 0; w_wd = 0;
            if (hold) begin
                e_req = 0; e_stall = 0; e_rd = hval;
            end else if (pend) begin
                e_req = 1; w_addr = p_addr; w_wen = p_wen; w_wd = p_wd;
                e_stall = !data_ack;
                e_rd = (data_ack && !kill && !FlushM && p_ld) ? ref_load(p_op, p_off, data_rdata) : 0;
            end else begin
                e_start = (MemReadM | MemWriteM) && !FlushM && !aerr;
                e_req = e_start;
                w_addr = {ALUOutM[31:2], 2'b00};
                w_wen = MemWriteM ? ref_wen(MemOpM, ALUOutM[1:0]) : 4'h0;
                w_wd = ref_wd(MemOpM, WriteDataM);
                e_stall = e_start && !data_ack;
                e_rd = (e_start && data_ack && MemReadM) ? ref_load(MemOpM, ALUOutM[1:0], data_rdata) : 0;
            end
            chk("r_req", data_req, e_req);
            if (e_req) begin
                chk("r_addr", data_addr, w_addr);
                chk("r_wen", data_wen, w_wen);
                chk("r_wdata", data_wdata, w_wd);
            end
            chk("r_stall", StallM, e_stall);
            chk("r_rd", ReadDataM, e_rd);
            chk("r_adel", AdelM, MemReadM & aerr);
            chk("r_ades", AdesM, MemWriteM & aerr);
`ifdef MEM_ADDR_EXC_EN
            chk("r_badv", BadVAddrM, ALUOutM);
`else
            chk("r_badv", BadVAddrM, 0);
`endif
            @(posedge clock);
            if (hold) hold = StallOtherM;
            else if (pend) begin
                if (data_ack) begin
                    pend = 0;
                    hold = StallOtherM && !kill && !FlushM;
                    hval = e_rd;
                end else if (FlushM) kill = 1;
            end else if (e_start) begin
                if (data_ack) begin
                    hold = StallOtherM;
                    hval = e_rd;
                end else begin
                    pend = 1; kill = 0;
                    p_addr = w_addr; p_wen = w_wen; p_wd = w_wd;
                    p_op = MemOpM; p_off = ALUOutM[1:0]; p_ld = MemReadM;
                end
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
